// File: rtl/seq_divider_addsub.sv
// rtl/seq_divider_addsub.sv - multi-cycle unsigned non-restoring divider with valid/ready channels
module seq_divider_addsub #(
    parameter int WIDTH = 36
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [WIDTH:0]   r_q, r_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0]   d_ext;
    logic [WIDTH:0]   step_s;
    logic [WIDTH:0]   step_r;
    logic [WIDTH:0]   fix_r;

    assign d_ext = {1'b0, d_q};

    // Partial remainder is two's complement; the add/sub choice follows its sign.
    always_comb begin
        step_s = {r_q[WIDTH-1:0], a_q[WIDTH-1]};
        step_r = r_q[WIDTH] ? (step_s + d_ext) : (step_s - d_ext);
        fix_r  = r_q[WIDTH] ? (r_q + d_ext) : r_q;
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        d_d     = d_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d   = dividend;
                    d_d   = divisor;
                    r_d   = '0;
                    cnt_d = CW'(WIDTH);
                    if (divisor == '0) begin
                        quot_d  = '1;
                        rem_d   = dividend;
                        dbz_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                r_d   = step_r;
                a_d   = {a_q[WIDTH-2:0], ~step_r[WIDTH]};
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                r_d     = fix_r;
                quot_d  = a_q;
                rem_d   = fix_r[WIDTH-1:0];
                dbz_d   = 1'b0;
                state_d = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            d_q     <= '0;
            r_q     <= '0;
            cnt_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            d_q     <= d_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign in_ready    = (state_q == S_IDLE);
    assign out_valid   = (state_q == S_DONE);
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;
endmodule
